// File: rtl/offset_canceller_if.sv
// Sample stream in from the ADC and offset-corrected stream out toward the integrator.
interface offset_canceller_if #(
   parameter int WIDTH = 14
);
   logic [WIDTH-1:0] i_tdata;
   logic             i_tvalid;
   logic [WIDTH:0]   o_tdata;
   logic             o_tvalid;
   logic             o_tready;

   modport master (
      output i_tdata, i_tvalid, o_tready,
      input  o_tdata, o_tvalid
   );

   modport slave (
      input  i_tdata, i_tvalid, o_tready,
      output o_tdata, o_tvalid
   );
endinterface

// File: rtl/offset_canceller.sv
// DC-offset removal for the ADC stream: subtracts a bypass/manual/auto-calibrated offset
// and produces a signed sample one bit wider, with a mean-based auto calibration.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for cal_start
// ST_ACCUM | summing 2^CAL_LOG2 samples, cal_busy high
// ST_LATCH | rounding the sum into cal_offset, pulse cal_done
module offset_canceller #(
   parameter int WIDTH    = 14,
   parameter int CAL_LOG2 = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   offset_canceller_if.slave strm,
   input  logic [7:0]        offset_mux,
   input  logic [15:0]       offset_value,
   input  logic              cal_start,
   output logic              cal_busy,
   output logic              cal_done,
   output logic [WIDTH-1:0]  cal_offset,
   output logic              overrun
);

   localparam int ACC_W = WIDTH + CAL_LOG2;
   localparam logic [ACC_W-1:0]    RND      = ACC_W'(1) << (CAL_LOG2 - 1);
   localparam logic [CAL_LOG2-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ACCUM = 2'b01,
      ST_LATCH = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CAL_LOG2-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]    cal_offset_q, cal_offset_d;
   logic                cal_done_q, cal_done_d;
   logic [WIDTH:0]      o_tdata_q, o_tdata_d;
   logic                o_tvalid_q, o_tvalid_d;
   logic                overrun_q, overrun_d;
   logic [WIDTH-1:0]    off;
   logic [ACC_W-1:0]    rounded;

   generate
      if (WIDTH < 16) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^offset_value[15:WIDTH];
      end
   endgenerate

   always_comb begin
      off = '0;
      case (offset_mux)
         8'h01:   off = offset_value[WIDTH-1:0];
         8'h02:   off = cal_offset_q;
         default: off = '0;
      endcase
   end

   always_comb begin
      o_tdata_d  = o_tdata_q;
      o_tvalid_d = o_tvalid_q;
      overrun_d  = overrun_q;
      if (clear) begin
         o_tdata_d  = '0;
         o_tvalid_d = 1'b0;
         overrun_d  = 1'b0;
      end else if (strm.i_tvalid) begin
         if (!o_tvalid_q || strm.o_tready) begin
            o_tvalid_d = 1'b1;
            o_tdata_d  = {1'b0, strm.i_tdata} - {1'b0, off};
         end else begin
            // held sample wins; the new one is lost
            overrun_d = 1'b1;
         end
      end else if (o_tvalid_q && strm.o_tready) begin
         o_tvalid_d = 1'b0;
      end
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      cal_offset_d = cal_offset_q;
      cal_done_d   = 1'b0;
      rounded      = acc_q + RND;
      if (clear) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cal_start) begin
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (cal_start) begin
                  acc_d = '0;
                  cnt_d = '0;
               end else if (strm.i_tvalid) begin
                  acc_d = acc_q + ACC_W'(strm.i_tdata);
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) state_d = ST_LATCH;
               end
            end
            ST_LATCH: begin
               cal_offset_d = rounded[ACC_W-1:CAL_LOG2];
               cal_done_d   = 1'b1;
               state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         cal_offset_q <= '0;
         cal_done_q   <= 1'b0;
         o_tdata_q    <= '0;
         o_tvalid_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         cal_offset_q <= cal_offset_d;
         cal_done_q   <= cal_done_d;
         o_tdata_q    <= o_tdata_d;
         o_tvalid_q   <= o_tvalid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign strm.o_tdata  = o_tdata_q;
   assign strm.o_tvalid = o_tvalid_q;
   assign cal_busy      = (state_q == ST_ACCUM);
   assign cal_done      = cal_done_q;
   assign cal_offset    = cal_offset_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_offset_canceller.sv
// Randomized and directed bench for offset_canceller against a queue-based reference model.
module tb_offset_canceller;
   localparam int W = 14;
   localparam int L = 4;
   localparam int N = 1 << L;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         clear = 1'b0;
   logic         cal_start = 1'b0;
   logic [7:0]   mux = 8'h00;
   logic [15:0]  ov = 16'h0000;
   logic         cal_busy, cal_done, overrun;
   logic [W-1:0] cal_offset;

   offset_canceller_if #(.WIDTH(W)) ifc ();

   offset_canceller #(.WIDTH(W), .CAL_LOG2(L)) dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .strm         (ifc.slave),
      .offset_mux   (mux),
      .offset_value (ov),
      .cal_start    (cal_start),
      .cal_busy     (cal_busy),
      .cal_done     (cal_done),
      .cal_offset   (cal_offset),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   bit m_valid = 0, m_ovr = 0, m_done = 0;
   int m_data = 0, m_cal_off = 0;
   int m_phase = 0;   // 0 idle, 1 collecting, 2 averaging next edge
   int cal_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit tv, input int d, input bit rdy, input bit cs);
      int off;
      int sum;
      m_done = 0;
      if (rst || clear) begin
         m_valid = 0; m_data = 0; m_ovr = 0; m_phase = 0;
         cal_q.delete();
         if (rst) m_cal_off = 0;
         return;
      end
      if (mux == 8'h01)      off = int'(ov[W-1:0]);
      else if (mux == 8'h02) off = m_cal_off;
      else                   off = 0;
      if (tv) begin
         if (!m_valid || rdy) begin
            m_valid = 1;
            m_data  = (d - off) & ((1 << (W + 1)) - 1);
         end else begin
            m_ovr = 1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      case (m_phase)
         0: if (cs) begin cal_q.delete(); m_phase = 1; end
         1: begin
            if (cs) cal_q.delete();
            else if (tv) begin
               cal_q.push_back(d);
               if (cal_q.size() == N) m_phase = 2;
            end
         end
         default: begin
            sum = 0;
            foreach (cal_q[i]) sum += cal_q[i];
            m_cal_off = (sum + N / 2) / N;
            m_done = 1;
            m_phase = 0;
         end
      endcase
   endtask

   task automatic cyc(input bit tv, input int d, input bit rdy, input bit cs);
      ifc.i_tvalid = tv;
      ifc.i_tdata  = d[W-1:0];
      ifc.o_tready = rdy;
      cal_start    = cs;
      @(posedge clk);
      model_edge(tv, d & ((1 << W) - 1), rdy, cs);
      #1;
      check_val("o_tvalid",   {31'd0, ifc.o_tvalid}, {31'd0, m_valid});
      check_val("o_tdata",    {17'd0, ifc.o_tdata},  m_data);
      check_val("overrun",    {31'd0, overrun},      {31'd0, m_ovr});
      check_val("cal_busy",   {31'd0, cal_busy},     (m_phase == 1) ? 1 : 0);
      check_val("cal_done",   {31'd0, cal_done},     {31'd0, m_done});
      check_val("cal_offset", {18'd0, cal_offset},   m_cal_off);
   endtask

   initial begin
      int d;
      bit tv, rdy, cs;
      ifc.i_tvalid = 1'b0;
      ifc.i_tdata  = '0;
      ifc.o_tready = 1'b1;

      // reset
      rst = 1'b1;
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      check_val("rst_tvalid", {31'd0, ifc.o_tvalid}, 0);
      check_val("rst_tdata",  {17'd0, ifc.o_tdata},  0);
      check_val("rst_caloff", {18'd0, cal_offset},   0);
      rst = 1'b0;

      // bypass
      mux = 8'h00;
      cyc(1, 'h1234, 0, 0);
      check_val("byp_data", {17'd0, ifc.o_tdata}, 'h01234);
      cyc(0, 0, 0, 0);
      check_val("byp_hold", {31'd0, ifc.o_tvalid}, 1);
      cyc(0, 0, 1, 0);
      check_val("byp_xfer", {31'd0, ifc.o_tvalid}, 0);

      // manual offset
      mux = 8'h01; ov = 16'h2000;
      cyc(1, 'h2005, 1, 0);
      check_val("man_pos", {17'd0, ifc.o_tdata}, 'h0005);
      cyc(1, 'h1FFB, 1, 0);
      check_val("man_neg", {17'd0, ifc.o_tdata}, 'h7FFB);
      ov = 16'hC000;   // upper bits ignored -> offset 0
      cyc(1, 'h0000, 1, 0);
      check_val("man_zero", {17'd0, ifc.o_tdata}, 'h0000);
      cyc(1, 'h3FFF, 1, 0);
      check_val("man_max", {17'd0, ifc.o_tdata}, 'h3FFF);
      cyc(0, 0, 1, 0);

      // auto calibration: alternating 100/101 rounds up to 101
      mux = 8'h00;
      cyc(0, 0, 1, 1);
      check_val("cal_busy_on", {31'd0, cal_busy}, 1);
      for (int i = 0; i < N; i++) cyc(1, 100 + (i % 2), 1, 0);
      cyc(0, 0, 1, 0);
      check_val("cal_done_pulse", {31'd0, cal_done}, 1);
      check_val("cal_off_101", {18'd0, cal_offset}, 101);
      cyc(0, 0, 1, 0);
      check_val("cal_done_low", {31'd0, cal_done}, 0);
      mux = 8'h02;
      cyc(1, 101, 1, 0);
      check_val("auto_zero", {17'd0, ifc.o_tdata}, 0);
      cyc(1, 100, 1, 0);
      check_val("auto_m1", {17'd0, ifc.o_tdata}, 'h7FFF);

      // restart after 7 samples, restart cycle carries a sample, then full-scale
      cyc(0, 0, 1, 1);
      for (int i = 0; i < 7; i++) cyc(1, 5, 1, 0);
      cyc(1, 'h3FFF, 1, 1);
      for (int i = 0; i < N - 1; i++) cyc(1, 'h3FFF, 1, 0);
      check_val("restart_busy", {31'd0, cal_busy}, 1);
      cyc(1, 'h3FFF, 1, 0);
      cyc(0, 0, 1, 0);
      check_val("fs_done", {31'd0, cal_done}, 1);
      check_val("fs_off", {18'd0, cal_offset}, 'h3FFF);

      // backpressure and overrun
      mux = 8'h00;
      cyc(0, 0, 1, 0);
      cyc(1, 'h0AAA, 0, 0);
      cyc(1, 'h0BBB, 0, 0);
      cyc(1, 'h0CCC, 0, 0);
      check_val("bp_hold", {17'd0, ifc.o_tdata}, 'h0AAA);
      check_val("bp_ovr", {31'd0, overrun}, 1);
      cyc(0, 0, 1, 0);
      check_val("bp_xfer", {31'd0, ifc.o_tvalid}, 0);
      check_val("bp_sticky", {31'd0, overrun}, 1);
      clear = 1'b1;
      cyc(0, 0, 1, 0);
      clear = 1'b0;
      check_val("clr_ovr", {31'd0, overrun}, 0);
      check_val("clr_keep_off", {18'd0, cal_offset}, 'h3FFF);

      // reset mid-calibration
      cyc(0, 0, 1, 1);
      for (int i = 0; i < 5; i++) cyc(1, 50, 1, 0);
      rst = 1'b1;
      cyc(0, 0, 1, 0);
      rst = 1'b0;
      check_val("rmid_busy", {31'd0, cal_busy}, 0);
      check_val("rmid_off", {18'd0, cal_offset}, 0);
      check_val("rmid_done", {31'd0, cal_done}, 0);
      cyc(0, 0, 1, 1);
      for (int i = 0; i < N; i++) cyc(1, 3 * i, 1, 0);   // sum 360 -> 22.5 -> 23
      cyc(0, 0, 1, 0);
      check_val("rmid_cal_done", {31'd0, cal_done}, 1);
      check_val("rmid_cal_off", {18'd0, cal_offset}, 23);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 4))
            0: mux = 8'h00;
            1: mux = 8'h01;
            2: mux = 8'h02;
            3: mux = 8'h03;
            default: mux = 8'($urandom);
         endcase
         ov    = 16'($urandom);
         clear = ($urandom_range(0, 199) == 0);
         cs    = ($urandom_range(0, 39) == 0);
         tv    = ($urandom_range(0, 2) != 0);
         rdy   = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0:       d = 0;
            1:       d = (1 << W) - 1;
            default: d = int'($urandom_range(0, (1 << W) - 1));
         endcase
         cyc(tv, d, rdy, cs);
      end
      clear = 1'b0;
      cyc(0, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
